// File: rtl/alu_share_if.sv
// Bus bundle between the ALU share arbiter, its two requesters and the shared ALU.
// The slave side is the arbiter; the master side is the requesters plus the ALU.
interface alu_share_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 3
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic [2*CODE_WIDTH-1:0] req_code;
  logic [13:0]             req_funct7;
  logic [1:0]              resp_valid;
  logic [1:0]              resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic [DATA_WIDTH-1:0]   alu_in_a;
  logic [DATA_WIDTH-1:0]   alu_in_b;
  logic [CODE_WIDTH-1:0]   alu_code;
  logic [6:0]              alu_funct7;
  logic [DATA_WIDTH-1:0]   alu_out;

  modport slave (
    input  req_valid, req_a, req_b, req_code, req_funct7, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, alu_in_a, alu_in_b, alu_code, alu_funct7
  );

  modport master (
    output req_valid, req_a, req_b, req_code, req_funct7, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, alu_in_a, alu_in_b, alu_code, alu_funct7
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with registered operands and result and valid/ready on both sides.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [6:0]            funct7_q, funct7_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic grant;
  logic have_req;

  // Both requesting: the one not served last wins; a lone requester always wins.
  always_comb begin
    have_req = |bus.req_valid;
    grant    = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    code_d       = code_q;
    funct7_d     = funct7_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (have_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          a_d          = grant ? bus.req_a[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_a[DATA_WIDTH-1:0];
          b_d          = grant ? bus.req_b[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_b[DATA_WIDTH-1:0];
          code_d       = grant ? bus.req_code[2*CODE_WIDTH-1:CODE_WIDTH] : bus.req_code[CODE_WIDTH-1:0];
          funct7_d     = grant ? bus.req_funct7[13:7] : bus.req_funct7[6:0];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        state_d  = RESP;
      end
      RESP: begin
        // Only the owner's ready retires the op; no new accept this cycle.
        if (bus.resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      code_q       <= '0;
      funct7_q     <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      code_q       <= code_d;
      funct7_q     <= funct7_d;
      result_q     <= result_d;
    end
  end

  // ALU inputs are held at zero outside EXEC so the ALU does not toggle while idle.
  always_comb begin
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    bus.alu_in_a   = '0;
    bus.alu_in_b   = '0;
    bus.alu_code   = '0;
    bus.alu_funct7 = '0;
    if (state_q == IDLE && have_req) bus.req_ready = grant ? 2'b10 : 2'b01;
    if (state_q == RESP) bus.resp_valid = owner_q ? 2'b10 : 2'b01;
    if (state_q == EXEC) begin
      bus.alu_in_a   = a_q;
      bus.alu_in_b   = b_q;
      bus.alu_code   = code_q;
      bus.alu_funct7 = funct7_q;
    end
  end

  assign bus.resp_data = result_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: plays both requesters and the shared ALU.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;

  alu_share_if #(.DATA_WIDTH(32), .CODE_WIDTH(3)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32), .CODE_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RV32 ALU standing in for the shared instance.
  always_comb begin
    case (bus.alu_code)
      3'd0: bus.alu_out = (bus.alu_funct7 == 7'h20) ? bus.alu_in_a - bus.alu_in_b
                                                    : bus.alu_in_a + bus.alu_in_b;
      3'd1: bus.alu_out = bus.alu_in_a << bus.alu_in_b[4:0];
      3'd2: bus.alu_out = {31'd0, $signed(bus.alu_in_a) < $signed(bus.alu_in_b)};
      3'd3: bus.alu_out = {31'd0, bus.alu_in_a < bus.alu_in_b};
      3'd4: bus.alu_out = bus.alu_in_a ^ bus.alu_in_b;
      3'd5: bus.alu_out = (bus.alu_funct7 == 7'h20) ? 32'($signed(bus.alu_in_a) >>> bus.alu_in_b[4:0])
                                                    : bus.alu_in_a >> bus.alu_in_b[4:0];
      3'd6: bus.alu_out = bus.alu_in_a | bus.alu_in_b;
      default: bus.alu_out = bus.alu_in_a & bus.alu_in_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] code, input logic [6:0] f7);
    bus.req_a[i*32 +: 32]     = a;
    bus.req_b[i*32 +: 32]     = b;
    bus.req_code[i*3 +: 3]    = code;
    bus.req_funct7[i*7 +: 7]  = f7;
    bus.req_valid[i]          = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_code   = '0;
    bus.req_funct7 = '0;
    bus.resp_ready = 2'b00;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_alu_a", bus.alu_in_a, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single ADD from requester 0
    set_req(0, 32'd5, 32'd7, 3'd0, 7'h00);
    bus.resp_ready = 2'b01;
    #1;
    chk("t1_ready", {30'd0, bus.req_ready}, 32'd1);
    chk("t1_alu_idle", bus.alu_in_a, 32'd0);
    step();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_exec_busy", {31'd0, busy}, 32'd1);
    chk("t1_exec_a", bus.alu_in_a, 32'd5);
    chk("t1_exec_b", bus.alu_in_b, 32'd7);
    chk("t1_exec_rv", {30'd0, bus.resp_valid}, 32'd0);
    step();
    chk("t1_resp_valid", {30'd0, bus.resp_valid}, 32'd1);
    chk("t1_resp_data", bus.resp_data, 32'd12);
    chk("t1_resp_alu", bus.alu_in_a, 32'd0);
    step();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_rv", {30'd0, bus.resp_valid}, 32'd0);

    // 2: simultaneous requests alternate, starting with requester 0 after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd1, 3'd0, 7'h00);
    set_req(1, 32'hF0, 32'h0F, 3'd4, 7'h00);
    bus.resp_ready = 2'b01;
    #1;
    chk("t2_grant0", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    #1;
    chk("t2_exec_ready", {30'd0, bus.req_ready}, 32'd0);
    step();
    chk("t2_resp0_valid", {30'd0, bus.resp_valid}, 32'd1);
    chk("t2_resp0_data", bus.resp_data, 32'd2);
    chk("t2_resp_ready", {30'd0, bus.req_ready}, 32'd0);
    step();
    bus.resp_ready = 2'b10;
    #1;
    chk("t2_grant1", {30'd0, bus.req_ready}, 32'd2);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    chk("t2_resp1_valid", {30'd0, bus.resp_valid}, 32'd2);
    chk("t2_resp1_data", bus.resp_data, 32'hFF);
    step();
    bus.req_valid = 2'b11;
    #1;
    chk("t2_grant_alt", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;

    // 3: SRA from requester 1 with a stalled response; requester 0 waits
    step();
    set_req(1, 32'h80000000, 32'd4, 3'd5, 7'h20);
    bus.resp_ready = 2'b00;
    #1;
    chk("t3_grant1", {30'd0, bus.req_ready}, 32'd2);
    step();
    bus.req_valid = 2'b00;
    #1;
    chk("t3_exec_code", {29'd0, bus.alu_code}, 32'd5);
    chk("t3_exec_f7", {25'd0, bus.alu_funct7}, 32'h20);
    step();
    set_req(0, 32'd9, 32'd9, 3'd0, 7'h00);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_rv", {30'd0, bus.resp_valid}, 32'd2);
      chk("t3_stall_data", bus.resp_data, 32'hF8000000);
      chk("t3_stall_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("t3_stall_busy", {31'd0, busy}, 32'd1);
      step();
    end
    bus.resp_ready = 2'b10;
    #1;
    chk("t3_release_ready", {30'd0, bus.req_ready}, 32'd0);
    step();
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);
    chk("t3_idle_grant0", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b01;

    // 4: signed vs unsigned compare on the same operands
    step();
    set_req(0, 32'hFFFFFFFF, 32'd1, 3'd2, 7'h00);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t4_slt", bus.resp_data, 32'd1);
    chk("t4_resp_alu_b", bus.alu_in_b, 32'd0);
    step();
    set_req(0, 32'hFFFFFFFF, 32'd1, 3'd3, 7'h00);
    #1;
    chk("t4_idle_alu_a", bus.alu_in_a, 32'd0);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t4_sltu", bus.resp_data, 32'd0);
    step();

    // 5: asynchronous reset during EXEC discards the op
    set_req(0, 32'd3, 32'd3, 3'd0, 7'h00);
    step();
    bus.req_valid = 2'b00;
    #1;
    chk("t5_exec_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_rv", {30'd0, bus.resp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd2, 3'd0, 7'h00);
    set_req(1, 32'd1, 32'd2, 3'd0, 7'h00);
    #1;
    chk("t5_grant0", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;
    step();
    chk("t5_no_resp", {30'd0, bus.resp_valid}, 32'd0);

    // 6: non-owner resp_ready does not retire the op
    set_req(0, 32'd3, 32'd4, 3'd0, 7'h00);
    bus.resp_ready = 2'b10;
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t6_resp_data", bus.resp_data, 32'd7);
    step();
    chk("t6_hold_rv", {30'd0, bus.resp_valid}, 32'd1);
    chk("t6_hold_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t6_hold_rv2", {30'd0, bus.resp_valid}, 32'd1);
    bus.resp_ready = 2'b01;
    step();
    chk("t6_done_busy", {31'd0, busy}, 32'd0);
    chk("t6_done_rv", {30'd0, bus.resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
